// File: rtl/sw_scan_pkg.sv
// Shared encodings for the switch scanner: scan modes and ping-pong direction.
package sw_scan_pkg;

    localparam logic [1:0] MODE_UP       = 2'b00;
    localparam logic [1:0] MODE_DOWN     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;

endpackage : sw_scan_pkg

// File: rtl/tick_gen.sv
// Scan prescaler: counts 0..TICK_DIV-1 and flags the cycle the count sits at TICK_DIV-1.
module tick_gen #(
    parameter int unsigned TICK_DIV = 33554432,
    localparam int unsigned PS_W    = $clog2(TICK_DIV)
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_en
);

    localparam logic [PS_W-1:0] CNT_LAST = PS_W'(TICK_DIV - 1);
    localparam logic [PS_W-1:0] CNT_PRE  = PS_W'(TICK_DIV - 2);

    logic [PS_W-1:0] cnt;

    // Free-running wrap counter; tick_en is registered one count early so it
    // is high exactly while cnt == TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            tick_en <= 1'b0;
        end else begin
            cnt     <= (cnt == CNT_LAST) ? '0 : cnt + PS_W'(1);
            tick_en <= (cnt == CNT_PRE);
        end
    end

endmodule : tick_gen

// File: rtl/sw_scan_display.sv
// Switch scanner: steps a channel index on a prescaled tick and shows a
// one-hot LED marker at that channel, lit only while its switch is on.
module sw_scan_display
    import sw_scan_pkg::*;
#(
    parameter int unsigned N_CH     = 8,
    parameter int unsigned TICK_DIV = 33554432,
    localparam int unsigned IDX_W   = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  sw,
    input  logic [1:0]       mode,
    input  logic             step,
    output logic [N_CH-1:0]  led,
    output logic [IDX_W-1:0] sel,
    output logic             tick
);

    localparam logic [IDX_W-1:0] SEL_LAST = IDX_W'(N_CH - 1);
    localparam logic [IDX_W-1:0] SEL_PEN  = IDX_W'(N_CH - 2);

    logic [N_CH-1:0]  sw_m;
    logic [N_CH-1:0]  sw_s;
    logic             tick_en;
    logic [0:0]       dir;
    logic [0:0]       dir_d;
    logic [IDX_W-1:0] sel_d;
    logic             advance;
    logic [N_CH-1:0]  onehot;
    logic [N_CH-1:0]  led_d;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_en (tick_en)
    );

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_m <= '0;
            sw_s <= '0;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
        end
    end

    // Index/direction state register plus the registered tick and LED outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel  <= '0;
            dir  <= DIR_UP;
            tick <= 1'b0;
            led  <= '0;
        end else begin
            sel  <= sel_d;
            dir  <= dir_d;
            tick <= tick_en;
            led  <= led_d;
        end
    end

    // Next index: HOLD advances only on step, every other mode on tick_en.
    always_comb begin
        sel_d   = sel;
        dir_d   = dir;
        advance = (mode == MODE_HOLD) ? step : tick_en;
        if (advance) begin
            case (mode)
                MODE_UP, MODE_HOLD: begin
                    sel_d = (sel == SEL_LAST) ? '0 : sel + IDX_W'(1);
                end
                MODE_DOWN: begin
                    sel_d = (sel == '0) ? SEL_LAST : sel - IDX_W'(1);
                end
                MODE_PINGPONG: begin
                    if (dir == DIR_UP) begin
                        if (sel == SEL_LAST) begin
                            dir_d = DIR_DOWN;
                            sel_d = SEL_PEN;
                        end else begin
                            sel_d = sel + IDX_W'(1);
                        end
                    end else begin
                        if (sel == '0) begin
                            dir_d = DIR_UP;
                            sel_d = IDX_W'(1);
                        end else begin
                            sel_d = sel - IDX_W'(1);
                        end
                    end
                end
                default: begin
                    sel_d = sel;
                end
            endcase
        end
    end

    // Marker at the current channel, blanked when that channel's switch is off.
    always_comb begin
        onehot = N_CH'(1) << sel;
        led_d  = sw_s[sel] ? onehot : '0;
    end

endmodule : sw_scan_display

// File: tb/tb_sw_scan_display.sv
// Randomised and directed bench for sw_scan_display; two instances (8 ch / div 4
// and 4 ch / div 2) are checked every cycle against a behavioural model.
module tb_sw_scan_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw;
    logic [1:0] mode;
    logic       step;

    logic [7:0] led_a;
    logic [2:0] sel_a;
    logic       tick_a;
    logic [3:0] led_b;
    logic [1:0] sel_b;
    logic       tick_b;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = 8-channel instance, 1 = 4-channel instance.
    int         m_cnt [2];
    int         m_sel [2];
    int         m_dir [2];  // 0 = up, 1 = down
    logic [7:0] m_led [2];
    logic       m_tick[2];
    logic [7:0] m_s1  [2];
    logic [7:0] m_s2  [2];

    always #5 clk = ~clk;

    sw_scan_display #(.N_CH(8), .TICK_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .sw(sw), .mode(mode), .step(step),
        .led(led_a), .sel(sel_a), .tick(tick_a)
    );

    sw_scan_display #(.N_CH(4), .TICK_DIV(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .sw(sw[3:0]), .mode(mode), .step(step),
        .led(led_b), .sel(sel_b), .tick(tick_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model of one instance across one rising edge.
    task automatic model_edge(input int k);
        int n, td, p, np;
        logic te, adv;
        n  = (k == 0) ? 8 : 4;
        td = (k == 0) ? 4 : 2;
        if (!rst_n) begin
            m_cnt[k] = 0; m_sel[k] = 0; m_dir[k] = 0;
            m_led[k] = '0; m_tick[k] = 1'b0; m_s1[k] = '0; m_s2[k] = '0;
        end else begin
            te        = (m_cnt[k] == td - 1);
            m_led[k]  = m_s2[k][m_sel[k]] ? 8'(1 << m_sel[k]) : 8'h00;
            m_tick[k] = te;
            adv       = (mode == 2'd3) ? step : te;
            if (adv) begin
                case (mode)
                    2'd0, 2'd3: m_sel[k] = (m_sel[k] + 1) % n;
                    2'd1:       m_sel[k] = (m_sel[k] + n - 1) % n;
                    default: begin
                        // Ping-pong as a walk around a ring of 2N-2 phases.
                        p  = (m_dir[k] == 0) ? m_sel[k] : (2*n - 2 - m_sel[k]) % (2*n - 2);
                        np = (p + 1) % (2*n - 2);
                        m_sel[k] = (np < n) ? np : 2*n - 2 - np;
                        m_dir[k] = (np >= n || np == 0) ? 1 : 0;
                    end
                endcase
            end
            m_cnt[k] = (m_cnt[k] + 1) % td;
            m_s2[k]  = m_s1[k];
            m_s1[k]  = (k == 0) ? sw : (sw & 8'h0F);
        end
    endtask

    // Drive inputs, take one edge, then compare both instances with the model.
    task automatic cycle(input logic r, input logic [7:0] s, input logic [1:0] m, input logic st);
        rst_n = r; sw = s; mode = m; step = st;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("sel_a",  32'(sel_a),  32'(m_sel[0]));
        check("led_a",  32'(led_a),  32'(m_led[0]));
        check("tick_a", 32'(tick_a), 32'(m_tick[0]));
        check("sel_b",  32'(sel_b),  32'(m_sel[1]));
        check("led_b",  32'(led_b),  32'(m_led[1][3:0]));
        check("tick_b", 32'(tick_b), 32'(m_tick[1]));
    endtask

    initial begin
        int guard;
        logic [7:0] rs;
        logic [1:0] rm;
        rst_n = 1'b0; sw = 8'hFF; mode = 2'd0; step = 1'b0;
        #1;

        // Reset and first tick.
        repeat (3) cycle(1'b0, 8'hFF, 2'd0, 1'b0);
        check("rst_sel", 32'(sel_a), 32'd0);
        check("rst_led", 32'(led_a), 32'd0);
        check("rst_tick", 32'(tick_a), 32'd0);
        repeat (3) cycle(1'b1, 8'hFF, 2'd0, 1'b0);
        check("pre_tick_sel", 32'(sel_a), 32'd0);
        cycle(1'b1, 8'hFF, 2'd0, 1'b0);
        check("first_tick_sel", 32'(sel_a), 32'd1);
        check("first_tick", 32'(tick_a), 32'd1);

        // UP sweeps with full and sparse switches.
        repeat (36) cycle(1'b1, 8'hFF, 2'd0, 1'b0);
        cycle(1'b0, 8'hFF, 2'd0, 1'b0);
        check("midscan_rst_sel", 32'(sel_a), 32'd0);
        check("midscan_rst_led", 32'(led_a), 32'd0);
        repeat (40) cycle(1'b1, 8'hA5, 2'd0, 1'b0);
        guard = 0;
        while (m_sel[0] != 0 && guard < 64) begin
            cycle(1'b1, 8'hA5, 2'd0, 1'b0);
            guard++;
        end
        if (guard >= 64) check("wait_sel0", 32'd0, 32'd1);
        repeat (4) cycle(1'b1, 8'hA4, 2'd0, 1'b0);

        // DOWN and PINGPONG from sel 0, then reset on the descending half.
        cycle(1'b0, 8'hFF, 2'd1, 1'b0);
        repeat (14) cycle(1'b1, 8'hFF, 2'd1, 1'b0);
        cycle(1'b0, 8'hFF, 2'd2, 1'b0);
        repeat (64) cycle(1'b1, 8'hFF, 2'd2, 1'b0);
        guard = 0;
        while (m_dir[0] != 1 && guard < 64) begin
            cycle(1'b1, 8'hFF, 2'd2, 1'b0);
            guard++;
        end
        if (guard >= 64) check("wait_desc", 32'd0, 32'd1);
        cycle(1'b0, 8'hFF, 2'd2, 1'b0);
        repeat (8) cycle(1'b1, 8'hFF, 2'd2, 1'b0);

        // HOLD with step pulses, including one coincident with tick_en.
        cycle(1'b0, 8'hFF, 2'd0, 1'b0);
        repeat (12) cycle(1'b1, 8'hFF, 2'd0, 1'b0);
        check("hold_entry_sel", 32'(sel_a), 32'd3);
        repeat (12) cycle(1'b1, 8'hFF, 2'd3, 1'b0);
        check("hold_frozen", 32'(sel_a), 32'd3);
        cycle(1'b1, 8'hFF, 2'd3, 1'b1);
        check("hold_step", 32'(sel_a), 32'd4);
        guard = 0;
        while (m_cnt[0] != 3 && guard < 8) begin
            cycle(1'b1, 8'hFF, 2'd3, 1'b0);
            guard++;
        end
        cycle(1'b1, 8'hFF, 2'd3, 1'b1);
        check("step_with_tick", 32'(sel_a), 32'd5);
        cycle(1'b1, 8'hFF, 2'd3, 1'b1);
        cycle(1'b1, 8'hFF, 2'd3, 1'b1);
        check("step_to_7", 32'(sel_a), 32'd7);
        cycle(1'b1, 8'hFF, 2'd3, 1'b1);
        check("step_wrap", 32'(sel_a), 32'd0);
        repeat (12) cycle(1'b1, 8'hFF, 2'd0, 1'b1);

        // Random traffic: mode held for runs, sparse steps, rare resets.
        rs = 8'h5A; rm = 2'd2;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) rs = 8'($urandom);
            if ($urandom_range(0, 31) == 0) rm = 2'($urandom);
            cycle(($urandom_range(0, 199) != 0), rs, rm, ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sw_scan_display

// File: doc/sw_scan_display.md
Name: sw_scan_display

Overview:
- Parametrised successor to the Basys3 switch-scanner top level.
- A prescaled tick steps a channel index across N_CH switch inputs. The LED array shows a one-hot marker at the selected channel, lit only when that channel's switch is on.
- Adds synchronised switch inputs, four scan modes (up, down, ping-pong, hold), manual stepping and synchronous reset.
- Sits directly under the board top; drives `led` and takes `sw`.

Parameters:
- N_CH, 8, number of switch/LED channels; legal range 2..256.
- TICK_DIV, 33554432, clk cycles per scan tick; must be ≥ 2 (2^25 ≈ 0.34 s at 100 MHz).
- IDX_W, $clog2(N_CH), derived localparam; width of channel index (not overridable).
- PS_W, $clog2(TICK_DIV), derived localparam; prescaler width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- sw  in  N_CH  raw switch inputs; asynchronous to clk.
- mode  in  2  scan mode: 00 UP, 01 DOWN, 10 PINGPONG, 11 HOLD.
- step  in  1  single-cycle manual advance pulse; honoured in HOLD only.
- led  out  N_CH  registered one-hot display, gated by the selected switch.
- sel  out  IDX_W  registered current channel index.
- tick  out  1  registered one-cycle pulse each prescaler wrap.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-low (`rst_n`). `rst_n` low at a rising edge overrides all other activity, including mid-scan.
- Reset values:
  - led = 0, sel = 0, tick = 0.
  - prescaler = 0, dir = UP.
  - both sync stages = 0.
- Switch sync: 2-flop synchroniser per bit, producing sw_s. A change sampled at edge E is visible in sw_s after edge E+1.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - The internal tick_en pulses for the one cycle the count equals TICK_DIV-1.
  - `tick` is tick_en registered: high the cycle after the count reaches TICK_DIV-1.
  - First tick_en occurs TICK_DIV cycles after reset release.
  - Runs in every mode.
- Index update on tick_en (sel changes at that edge):
  - UP: sel = (sel == N_CH-1) ? 0 : sel+1.
  - DOWN: sel = (sel == 0) ? N_CH-1 : sel-1.
  - PINGPONG:
    - dir UP: if sel == N_CH-1, then dir = DOWN and sel = N_CH-2; otherwise sel+1.
    - dir DOWN: if sel == 0, then dir = UP and sel = 1; otherwise sel-1.
    - End points are never repeated.
  - HOLD: tick_en is ignored; sel is frozen.
- Step: in HOLD, step high at an edge advances sel as in UP, wrapping N_CH-1 → 0. Step in other modes is ignored. In HOLD, step and tick_en in the same cycle give exactly one advance.
- Mode change:
  - Sampled at each edge; the new mode applies on the next tick_en or step.
  - dir persists across mode changes and affects only PINGPONG.
  - Entering PINGPONG with dir = DOWN at sel = 0 gives next sel = 1.
- LED: every cycle, led = onehot(sel) & {N_CH{sw_s[sel]}}, registered.
  - led lags a sel change by 1 cycle.
  - A raw sw change at edge E reaches led at edge E+2.

Decomposition:
- Package sw_scan_pkg: mode localparams MODE_UP = 2'b00, MODE_DOWN = 2'b01, MODE_PINGPONG = 2'b10, MODE_HOLD = 2'b11; dir encoding DIR_UP = 1'b0, DIR_DOWN = 1'b1.
- Sub-module tick_gen (parameter TICK_DIV; ports clk, rst_n, tick_en) contains the prescaler.
- Synchroniser, index FSM and LED register stay in the top.

Test Plan (N_CH = 8, TICK_DIV = 4 unless noted):
1. Reset: rst_n low for 3 cycles with sw = FF, mode = UP → led = 00, sel = 0, tick = 0. Release → first tick_en on the 4th edge after release; sel goes 0 → 1. Assert rst_n mid-scan → sel = 0, led = 00 on the next edge.
2. UP, sw = FF → sel steps 0,1,…,7,0 every 4 cycles; led follows 01,02,04,…,80,01, one cycle after sel.
3. UP, sw = A5 → over one sweep led = 01,00,04,00,00,20,00,80. Toggle sw[0] 1 → 0 while sel = 0 → led goes 00 exactly 2 edges later.
4. DOWN from sel = 0 → 7,6,5; PINGPONG from sel = 0 → 0,1,…,7,6,…,0,1 with no repeated endpoints. Reset during the descending half → sel = 0, dir = UP, next tick gives sel = 1.
5. HOLD at sel = 3 for 3 ticks → sel stays 3. One step pulse → sel = 4. Step coincident with tick_en → sel = 5, not 6. Step at sel = 7 → sel = 0. Step in UP mode → no extra advance.
6. N_CH = 4, TICK_DIV = 2, PINGPONG → sel = 0,1,2,3,2,1,0,1 on successive ticks; tick high one cycle in every 2.
